ram_access_controller: RTL and testbench
========================================

Name: ram_access_controller

Overview:
- Initiator side of the RAM port. Turns single-beat CPU/loader requests (valid/ready) into the RAM's control sequence:
  - address load (addressEn)
  - then write (writeEn) or tri-state read (outEnable + data/program select)
- Read data is sampled from the shared 8-bit bus and returned on a registered response channel (valid/ready).
- Sits between the control unit and the RAM, and is the only driver of the RAM control pins.

Parameters:
- DATA_WIDTH, 8, width of data bus and write data.
- ADDR_WIDTH, 8, width of RAM address (wraps mod 2^ADDR_WIDTH).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_reqValid  in  1  request valid.
- o_reqReady  out  1  controller can accept a request.
- i_reqAddress  in  ADDR_WIDTH  request address.
- i_reqWrite  in  1  1 = write, 0 = read.
- i_reqData  in  DATA_WIDTH  write data.
- i_reqSelect  in  1  read section: 1 = data, 0 = program.
- i_reqLength  in  4  burst beats minus 1; used only with RAM_BURST_EN.
- o_rspValid  out  1  read data valid.
- i_rspReady  in  1  consumer accepts read data.
- o_rspData  out  DATA_WIDTH  read data.
- o_address  out  ADDR_WIDTH  to RAM i_address.
- o_addressEn  out  1  to RAM i_addressEn.
- o_writeData  out  DATA_WIDTH  to RAM i_writeData.
- o_writeEn  out  1  to RAM i_writeEn.
- o_readDataSelect  out  1  to RAM i_readDataSelect.
- o_outEnable  out  1  to RAM i_outEnable.
- i_busData  in  DATA_WIDTH  shared bus, carries RAM read data when o_outEnable = 1.

Behaviour:
- Single clock i_clk. Synchronous active-high i_reset forces state IDLE and all outputs to 0. Exception: o_reqReady = 1 in IDLE after reset.
- FSM states:
  - IDLE: o_reqReady = 1. On i_reqValid, latch address/write/data/select/length; go to ADDR.
  - ADDR: o_addressEn = 1, o_address = latched address; go to ACCESS.
  - ACCESS:
    - Write: o_writeEn = 1, o_writeData = latched data, o_readDataSelect = 1 (RAM writes always hit data section; i_reqSelect ignored for writes). Next state IDLE.
    - Read: o_outEnable = 1, o_readDataSelect = latched select. i_busData registered into o_rspData at end of cycle. Next state RESP.
  - RESP: o_rspValid = 1, o_rspData held stable. On i_rspReady, go to IDLE (or ADDR for the next burst beat).
- o_reqReady is 1 only in IDLE. No request is accepted while busy. Request fields are don't-care outside the accept cycle.
- Latency, with accept edge = cycle 0:
  - ADDR in cycle 1, ACCESS in cycle 2.
  - Read: o_rspValid rises in cycle 3.
  - Write: back in IDLE (o_reqReady = 1) in cycle 3.
  - Minimum 3-cycle issue interval.
- o_outEnable is asserted only in read ACCESS, never together with o_writeEn. Bus contention is a bug.
- All RAM control outputs are registered (driven from state flops), glitch-free.
- Response held with i_rspReady = 0: stays in RESP indefinitely, o_rspData unchanged, no RAM activity.
- Reset mid-operation: next edge returns to IDLE. Pending response dropped, o_writeEn/o_outEnable deasserted.
- Address arithmetic: ADDR_WIDTH bits, 0xFF + 1 = 0x00. No error flag.

Optional Feature:
- Macro RAM_BURST_EN.
- Defined:
  - Reads perform i_reqLength+1 beats (1–16).
  - After each RESP handshake: address += 1 (wrapping), beat counter -= 1, return to ADDR.
  - IDLE only after the last beat's handshake.
  - Writes ignore length (single beat).
- Undefined: i_reqLength ignored; every request is a single beat; no counter logic.

Test Plan:
- Reset then idle: after i_reset is held 2 cycles -> o_reqReady = 1, all other outputs 0.
- Write 0x5A to 0x10: accept -> cycle 1 o_addressEn = 1, o_address = 0x10; cycle 2 o_writeEn = 1, o_writeData = 0x5A, o_readDataSelect = 1, o_outEnable = 0; cycle 3 o_reqReady = 1.
- Read program addr 0x10, bus model returns 0xC3: cycle 2 o_outEnable = 1, o_readDataSelect = 0; cycle 3 o_rspValid = 1, o_rspData = 0xC3.
- Back-pressure: read with i_rspReady = 0 for 5 cycles, bus value changed meanwhile -> o_rspData stays 0xC3, o_reqReady = 0, no o_addressEn until ready.
- Reset during ACCESS of a write -> o_writeEn = 0 next cycle, state IDLE, no o_rspValid.
- With RAM_BURST_EN: read addr 0xFE, length 2 -> three responses from addresses 0xFE, 0xFF, 0x00; then IDLE.

Source files
------------

// File: rtl/ram_access_controller.sv
// Initiator for the RAM port: turns valid/ready requests into address-load then write/read strobes.
// Optional multi-beat reads are enabled with the RAM_BURST_EN macro.
module ram_access_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_reqValid,
  output logic                  o_reqReady,
  input  logic [ADDR_WIDTH-1:0] i_reqAddress,
  input  logic                  i_reqWrite,
  input  logic [DATA_WIDTH-1:0] i_reqData,
  input  logic                  i_reqSelect,
  input  logic [3:0]            i_reqLength,
  output logic                  o_rspValid,
  input  logic                  i_rspReady,
  output logic [DATA_WIDTH-1:0] o_rspData,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_addressEn,
  output logic [DATA_WIDTH-1:0] o_writeData,
  output logic                  o_writeEn,
  output logic                  o_readDataSelect,
  output logic                  o_outEnable,
  input  logic [DATA_WIDTH-1:0] i_busData
);

  typedef enum logic [1:0] {StIdle, StAddr, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sel_q, sel_d;

  logic                  req_ready_q, req_ready_d;
  logic                  address_en_q, address_en_d;
  logic                  write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  read_sel_q, read_sel_d;
  logic                  out_en_q, out_en_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef RAM_BURST_EN
  logic [3:0]            beats_q, beats_d;
`else
  logic                  unused_length;
  assign unused_length = ^i_reqLength;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    data_d     = data_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
`ifdef RAM_BURST_EN
    beats_d    = beats_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_reqValid) begin
          addr_d  = i_reqAddress;
          write_d = i_reqWrite;
          data_d  = i_reqData;
          sel_d   = i_reqSelect;
`ifdef RAM_BURST_EN
          beats_d = i_reqWrite ? 4'd0 : i_reqLength;
`endif
          state_d = StAddr;
        end
      end
      StAddr: state_d = StAccess;
      StAccess: begin
        // The RAM drives the bus during this cycle; capture it on the closing edge.
        if (!write_q) begin
          rsp_data_d = i_busData;
        end
        state_d = write_q ? StIdle : StResp;
      end
      StResp: begin
        if (i_rspReady) begin
`ifdef RAM_BURST_EN
          if (beats_q != 4'd0) begin
            beats_d = beats_q - 4'd1;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = StAddr;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so every RAM pin comes straight off a flop.
    req_ready_d  = (state_d == StIdle);
    address_en_d = (state_d == StAddr);
    write_en_d   = (state_d == StAccess) && write_q;
    out_en_d     = (state_d == StAccess) && !write_q;
    write_data_d = write_en_d ? data_q : '0;
    read_sel_d   = write_en_d | (out_en_d & sel_q);
    rsp_valid_d  = (state_d == StResp);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      write_q      <= 1'b0;
      data_q       <= '0;
      sel_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      address_en_q <= 1'b0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      read_sel_q   <= 1'b0;
      out_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
`ifdef RAM_BURST_EN
      beats_q      <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      req_ready_q  <= req_ready_d;
      address_en_q <= address_en_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      read_sel_q   <= read_sel_d;
      out_en_q     <= out_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
`ifdef RAM_BURST_EN
      beats_q      <= beats_d;
`endif
    end
  end

  assign o_reqReady       = req_ready_q;
  assign o_rspValid       = rsp_valid_q;
  assign o_rspData        = rsp_data_q;
  assign o_address        = addr_q;
  assign o_addressEn      = address_en_q;
  assign o_writeData      = write_data_q;
  assign o_writeEn        = write_en_q;
  assign o_readDataSelect = read_sel_q;
  assign o_outEnable      = out_en_q;

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: mock RAM on the pins, reference memory contents kept separately.
module tb_ram_access_controller;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_reqValid;
  logic       o_reqReady;
  logic [7:0] i_reqAddress;
  logic       i_reqWrite;
  logic [7:0] i_reqData;
  logic       i_reqSelect;
  logic [3:0] i_reqLength;
  logic       o_rspValid;
  logic       i_rspReady;
  logic [7:0] o_rspData;
  logic [7:0] o_address;
  logic       o_addressEn;
  logic [7:0] o_writeData;
  logic       o_writeEn;
  logic       o_readDataSelect;
  logic       o_outEnable;
  logic [7:0] i_busData;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] dmem [256];
  logic [7:0] pmem [256];
  logic [7:0] ref_dmem [256];
  logic [7:0] ram_addr;
  logic [7:0] bus_other;
  logic       mem_load;
  logic [7:0] addr_log [$];

  always #5 i_clk = ~i_clk;

  ram_access_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_reqValid(i_reqValid), .o_reqReady(o_reqReady), .i_reqAddress(i_reqAddress),
    .i_reqWrite(i_reqWrite), .i_reqData(i_reqData), .i_reqSelect(i_reqSelect),
    .i_reqLength(i_reqLength), .o_rspValid(o_rspValid), .i_rspReady(i_rspReady),
    .o_rspData(o_rspData), .o_address(o_address), .o_addressEn(o_addressEn),
    .o_writeData(o_writeData), .o_writeEn(o_writeEn), .o_readDataSelect(o_readDataSelect),
    .o_outEnable(o_outEnable), .i_busData(i_busData)
  );

  // Mock RAM: latches address on addressEn, writes data section, drives bus on outEnable.
  always @(posedge i_clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) dmem[i] <= ref_dmem[i];
    end else begin
      if (o_addressEn) ram_addr <= o_address;
      if (o_writeEn) dmem[ram_addr] <= o_writeData;
    end
  end

  assign i_busData = o_outEnable ? (o_readDataSelect ? dmem[ram_addr] : pmem[ram_addr])
                                 : bus_other;

  always @(negedge i_clk) begin
    if (o_addressEn) addr_log.push_back(o_address);
    if (o_outEnable || o_writeEn) begin
      n_cmp++;
      if (o_outEnable && o_writeEn) begin
        n_fail++;
        $display("FAIL contention: outEnable=%0b writeEn=%0b required not both", o_outEnable,
                 o_writeEn);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic wr, input logic [7:0] d,
                        input logic sel, input logic [3:0] len);
    i_reqValid = 1'b1; i_reqAddress = a; i_reqWrite = wr; i_reqData = d;
    i_reqSelect = sel; i_reqLength = len;
    step();
    i_reqValid = 1'b0;
    i_reqAddress = 8'($urandom); i_reqWrite = 1'($urandom); i_reqData = 8'($urandom);
    i_reqSelect = 1'($urandom); i_reqLength = 4'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    accept(a, 1'b1, d, 1'($urandom), 4'($urandom));
    chk("wr_c1_addr", {o_addressEn, o_address, o_writeEn, o_outEnable}, {1'b1, a, 2'b00});
    step();
    chk("wr_c2_strobe", {o_writeEn, o_writeData, o_readDataSelect, o_outEnable},
        {1'b1, d, 1'b1, 1'b0});
    step();
    chk("wr_c3_ready", {o_reqReady, o_writeEn, o_rspValid}, {1'b1, 2'b00});
    ref_dmem[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input logic sel, input logic [3:0] len);
    int beats;
    logic [7:0] ab;
    logic [7:0] exp;
    int n;
`ifdef RAM_BURST_EN
    beats = int'(len) + 1;
`else
    beats = 1;
`endif
    accept(a, 1'b0, 8'($urandom), sel, len);
    chk("rd_c1_addr", {o_addressEn, o_address, o_reqReady}, {1'b1, a, 1'b0});
    step();
    chk("rd_c2_oe", {o_outEnable, o_readDataSelect, o_writeEn}, {1'b1, sel, 1'b0});
    step();
    chk("rd_c3_valid", {31'd0, o_rspValid}, 32'd1);
    for (int b = 0; b < beats; b++) begin
      ab = a + 8'(b);
      exp = sel ? ref_dmem[ab] : pmem[ab];
      n = 0;
      while (!o_rspValid && n < 20) begin
        step();
        n++;
      end
      if (!o_rspValid) begin
        n_cmp++; n_fail++;
        $display("FAIL rd_timeout: beat %0d no rspValid required 1", b);
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        bus_other = 8'($urandom);
        step();
      end
      chk("rd_data", {24'd0, o_rspData}, {24'd0, exp});
      i_rspReady = 1'b1;
      step();
      i_rspReady = 1'b0;
      if (b == beats - 1) chk("rd_done_ready", {o_reqReady, o_rspValid}, 2'b10);
      else chk("rd_next_addr", {o_addressEn, o_address, o_reqReady}, {1'b1, ab + 8'd1, 1'b0});
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; mem_load = 1'b1;
    step();
    mem_load = 1'b0;
    step();
    chk("reset_ready", {31'd0, o_reqReady}, 32'd1);
    chk("reset_ctrl", {o_addressEn, o_writeEn, o_outEnable, o_readDataSelect, o_rspValid},
        5'b0);
    chk("reset_data", {o_address, o_writeData, o_rspData}, 24'd0);
    i_reset = 1'b0;
    step();
    chk("idle_ready", {o_reqReady, o_addressEn}, 2'b10);
  endtask

  task automatic test_write();
    do_write(8'h10, 8'h5A);
  endtask

  task automatic test_read_program();
    do_read(8'h10, 1'b0, 4'd0);
  endtask

  task automatic test_back_pressure();
    accept(8'h10, 1'b0, 8'h00, 1'b0, 4'd0);
    step();
    step();
    chk("bp_valid", {o_rspValid, o_rspData}, {1'b1, 8'hC3});
    repeat (5) begin
      bus_other = ~bus_other;
      step();
      chk("bp_hold", {o_rspValid, o_rspData, o_reqReady, o_addressEn, o_outEnable},
          {1'b1, 8'hC3, 3'b000});
    end
    i_rspReady = 1'b1;
    step();
    i_rspReady = 1'b0;
    chk("bp_release", {o_reqReady, o_rspValid}, 2'b10);
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    d = 8'($urandom);
    accept(8'h77, 1'b1, d, 1'b0, 4'd0);
    step();
    chk("rst_mid_we", {31'd0, o_writeEn}, 32'd1);
    i_reset = 1'b1;
    step();
    chk("rst_mid_after", {o_writeEn, o_outEnable, o_rspValid, o_reqReady, o_addressEn},
        5'b00010);
    i_reset = 1'b0;
    ref_dmem[8'h77] = d;  // the strobe was high through that cycle, so the RAM took it
    step();
    chk("rst_mid_idle", {o_reqReady, o_rspValid}, 2'b10);
  endtask

  task automatic test_burst();
`ifdef RAM_BURST_EN
    addr_log.delete();
    do_read(8'hFE, 1'b1, 4'd2);
    chk("burst_nlog", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3)
      chk("burst_addrs", {addr_log[0], addr_log[1], addr_log[2]}, {8'hFE, 8'hFF, 8'h00});
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 1'b1, 4'($urandom_range(0, 3)));
        default: do_read(8'($urandom), 1'b0, 4'($urandom_range(0, 3)));
      endcase
      repeat ($urandom_range(0, 2)) begin
        bus_other = 8'($urandom);
        step();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_reqValid = 1'b0; i_reqAddress = '0; i_reqWrite = 1'b0;
    i_reqData = '0; i_reqSelect = 1'b0; i_reqLength = '0; i_rspReady = 1'b0;
    bus_other = 8'hA5; mem_load = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_dmem[i] = 8'($urandom);
      pmem[i] = 8'($urandom);
    end
    pmem[8'h10] = 8'hC3;
    test_reset();
    test_write();
    test_read_program();
    test_back_pressure();
    test_reset_mid_write();
    test_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
